// File: rtl/fifo_ptr_pkg.sv
// Pointer helpers shared by the read- and write-side FIFO controllers.
// Functions work on a wide container; callers zero-extend and slice to their own width.
package fifo_ptr_pkg;

    localparam int PTR_MAX_W = 32;

    typedef logic [PTR_MAX_W-1:0] ptr_t;

    function automatic ptr_t bin2gray(input ptr_t bin);
        return bin ^ (bin >> 1);
    endfunction

    // Leading zeros from zero-extension leave the low bits of the result unchanged.
    function automatic ptr_t gray2bin(input ptr_t gray);
        ptr_t bin;
        bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational gray-to-binary converter: each binary bit is the XOR of all gray bits at or above it.
module gray_to_bin #(
    parameter int W = 5
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign bin[i] = ^gray[W-1:i];
    end

endmodule

// File: rtl/fifo_read_ctrl.sv
// Read-domain pointer/flag controller of the asynchronous FIFO.
// rd_en is a request qualified by ~empty; each accepted read yields rd_valid exactly one cycle later.
module fifo_read_ctrl
    import fifo_ptr_pkg::*;
#(
    parameter int n               = 4,
    parameter int ALMOST_EMPTY_TH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         rd_en,
    input  logic [n:0]   gray_counter_write_sync,
    output logic [n-1:0] rd_addr,
    output logic [n:0]   gray_counter_read,
    output logic         empty,
    output logic         almost_empty,
    output logic [n:0]   rd_level,
    output logic         rd_valid,
    output logic         underflow
);

    localparam logic [n:0] AE_TH = (n+1)'(ALMOST_EMPTY_TH);

    logic [n:0] rd_bin;
    logic [n:0] wr_bin;
    logic [n:0] rd_bin_next;
    logic [n:0] rd_gray_next;
    logic [n:0] rd_level_next;
    logic       accept;
    ptr_t       gray_wide;

    gray_to_bin #(.W(n+1)) u_wr_g2b (
        .gray (gray_counter_write_sync),
        .bin  (wr_bin)
    );

    // Flags are computed from the post-read pointer so emptiness is never a cycle late.
    always_comb begin
        accept        = rd_en & ~empty;
        rd_bin_next   = rd_bin + {{n{1'b0}}, accept};
        gray_wide     = bin2gray(ptr_t'(rd_bin_next));
        rd_gray_next  = gray_wide[n:0];
        rd_level_next = wr_bin - rd_bin_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_bin            <= '0;
            gray_counter_read <= '0;
            empty             <= 1'b1;
            almost_empty      <= 1'b1;
            rd_level          <= '0;
            rd_valid          <= 1'b0;
            underflow         <= 1'b0;
        end else begin
            rd_bin            <= rd_bin_next;
            gray_counter_read <= rd_gray_next;
            empty             <= (rd_gray_next == gray_counter_write_sync);
            almost_empty      <= (rd_level_next <= AE_TH);
            rd_level          <= rd_level_next;
            rd_valid          <= accept;
            underflow         <= rd_en & empty;
        end
    end

    assign rd_addr = rd_bin[n-1:0];

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Bench for fifo_read_ctrl: vector table, hand sequences and randomized traffic against a word-count model.
module tb_fifo_read_ctrl;

    localparam int N  = 4;
    localparam int TH = 2;
    localparam int DEPTH = 1 << N;

    logic         clk;
    logic         rst_n;
    logic         rd_en;
    logic [N:0]   gray_counter_write_sync;
    logic [N-1:0] rd_addr;
    logic [N:0]   gray_counter_read;
    logic         empty;
    logic         almost_empty;
    logic [N:0]   rd_level;
    logic         rd_valid;
    logic         underflow;

    fifo_read_ctrl #(.n(N), .ALMOST_EMPTY_TH(TH)) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .rd_en                   (rd_en),
        .gray_counter_write_sync (gray_counter_write_sync),
        .rd_addr                 (rd_addr),
        .gray_counter_read       (gray_counter_read),
        .empty                   (empty),
        .almost_empty            (almost_empty),
        .rd_level                (rd_level),
        .rd_valid                (rd_valid),
        .underflow               (underflow)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass;
    int n_total;

    // model: total words written and read since reset, as plain integers
    int wr_count;
    int rd_count;
    bit m_empty;
    bit m_valid;
    bit m_uf;

    typedef struct {
        bit rd;
        int wr_step;
        int level;
        bit emp;
        bit ae;
        bit valid;
        bit uf;
        int addr;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [N:0] gray_of(input int count);
        logic [N:0] b;
        b = (N+1)'(count % (2 * DEPTH));
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        n_total++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    endtask

    task automatic check_model();
        int lvl;
        lvl = wr_count - rd_count;
        check("level",        int'(rd_level),          lvl);
        check("empty",        int'(empty),             int'(lvl == 0));
        check("almost_empty", int'(almost_empty),      int'(lvl <= TH));
        check("rd_addr",      int'(rd_addr),           rd_count % DEPTH);
        check("gray_read",    int'(gray_counter_read), int'(gray_of(rd_count)));
        check("rd_valid",     int'(rd_valid),          int'(m_valid));
        check("underflow",    int'(underflow),         int'(m_uf));
    endtask

    // one clock: drive, advance model, sample #1 after the edge
    task automatic cycle(input bit rd, input int wr_step);
        bit acc;
        rd_en = rd;
        wr_count += wr_step;
        gray_counter_write_sync = gray_of(wr_count);
        acc = rd && !m_empty;
        m_uf = rd && m_empty;
        m_valid = acc;
        if (acc) rd_count++;
        m_empty = (wr_count == rd_count);
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        rd_en = 1'b0;
        gray_counter_write_sync = '0;
        wr_count = 0;
        rd_count = 0;
        m_empty = 1'b1;
        m_valid = 1'b0;
        m_uf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_model();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        do_reset();

        // rd, wr_step, level, empty, almost_empty, valid, underflow, addr
        vecs.push_back('{0, 1, 1, 0, 1, 0, 0, 0});
        vecs.push_back('{0, 1, 2, 0, 1, 0, 0, 0});
        vecs.push_back('{0, 1, 3, 0, 0, 0, 0, 0});
        vecs.push_back('{0, 0, 3, 0, 0, 0, 0, 0});
        vecs.push_back('{1, 0, 2, 0, 1, 1, 0, 1});
        vecs.push_back('{1, 0, 1, 0, 1, 1, 0, 2});
        vecs.push_back('{1, 0, 0, 1, 1, 1, 0, 3});
        vecs.push_back('{1, 0, 0, 1, 1, 0, 1, 3});
        vecs.push_back('{0, 0, 0, 1, 1, 0, 0, 3});
        vecs.push_back('{1, 1, 1, 0, 1, 0, 1, 3});
        vecs.push_back('{1, 1, 1, 0, 1, 1, 0, 4});
        vecs.push_back('{1, 0, 0, 1, 1, 1, 0, 5});

        foreach (vecs[i]) begin
            cycle(vecs[i].rd, vecs[i].wr_step);
            check($sformatf("vec%0d_level", i), int'(rd_level),     vecs[i].level);
            check($sformatf("vec%0d_empty", i), int'(empty),        int'(vecs[i].emp));
            check($sformatf("vec%0d_ae", i),    int'(almost_empty), int'(vecs[i].ae));
            check($sformatf("vec%0d_valid", i), int'(rd_valid),     int'(vecs[i].valid));
            check($sformatf("vec%0d_uf", i),    int'(underflow),    int'(vecs[i].uf));
            check($sformatf("vec%0d_addr", i),  int'(rd_addr),      vecs[i].addr);
        end

        // asynchronous reset in the middle of traffic
        cycle(0, 1);
        cycle(0, 1);
        cycle(1, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_empty",   int'(empty),             1);
        check("async_ae",      int'(almost_empty),      1);
        check("async_level",   int'(rd_level),          0);
        check("async_gray",    int'(gray_counter_read), 0);
        check("async_addr",    int'(rd_addr),           0);
        check("async_valid",   int'(rd_valid),          0);
        do_reset();

        // full level: write pointer 16 ahead, gray 11000
        for (int i = 0; i < DEPTH; i++) cycle(0, 1);
        check("full_sync_gray", int'(gray_counter_write_sync), int'(5'b11000));
        check("full_level", int'(rd_level), DEPTH);
        check("full_empty", int'(empty), 0);
        check("full_ae",    int'(almost_empty), 0);
        for (int i = 0; i < DEPTH; i++) cycle(1, 0);
        check("drained_empty", int'(empty), 1);

        // 40 write/read pairs, crossing the 31->0 wrap
        for (int i = 0; i < 40; i++) cycle(1, 1);
        check("wrap_reached", int'(rd_count > 2 * DEPTH), 1);

        // randomized traffic, write step bounded so level never exceeds depth
        for (int i = 0; i < 400; i++) begin
            int step;
            step = $urandom_range(0, 1);
            if (wr_count + step - rd_count > DEPTH) step = 0;
            cycle(1'($urandom_range(0, 1)), step);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
